// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and constants for the sequential multiply/divide unit.
//   mdu_op_t    : RV M-extension funct3 encodings
//   mdu_state_t : mdu_seq controller states
//   MDU_FUNCT7  : funct7 value that selects the M extension
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CALC  = 2'b01,
    ST_FIXUP = 2'b10,
    ST_DONE  = 2'b11
  } mdu_state_t;

  localparam logic [6:0] MDU_FUNCT7 = 7'b0000001;

  // Divide family is funct3[2]=1; remainder ops additionally have funct3[1]=1.
  function automatic logic op_is_div(mdu_op_t op);
    return op[2];
  endfunction

endpackage

// File: rtl/mdu_neg.sv
// mdu_neg: conditional two's-complement negator.
//   a   : value in
//   neg : 1 = output -a, 0 = pass a through
//   y   : result
module mdu_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic         neg,
  output logic [W-1:0] y
);

  assign y = neg ? (~a + {{(W-1){1'b0}}, 1'b1}) : a;

endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: sequential RV M-extension multiply/divide unit.
// Shift-add multiply and restoring divide on operand magnitudes, one bit per
// CALC cycle, with a sign fix-up at the end.
//   clk     : clock, rising edge
//   reset   : asynchronous active-low reset
//   start   : request, sampled only in IDLE
//   funct3  : operation (mdu_op_t)
//   srcA    : rs1 (multiplicand / dividend)
//   srcB    : rs2 (multiplier / divisor)
//   kill    : abort operation in flight; blocks accept in IDLE
//   busy    : high in CALC, FIXUP, DONE
//   done    : one-cycle pulse, result valid
//   result  : result, held until the next accepted request
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one product/quotient bit per cycle, XLEN cycles
// FIXUP | sign correction and result select
// DONE  | result registered, done pulses on the following cycle
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam int PW    = 2 * XLEN;

  mdu_state_t state_q, state_d;

  mdu_op_t         op_in, op_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [PW-1:0]   prod_q;
  logic [CNT_W-1:0] cnt_q;
  logic            res_neg_q;
  logic [XLEN-1:0] result_q;
  logic            done_q;

  logic            accept;
  logic            a_signed, b_signed, neg_a, neg_b, res_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, fast;
  logic [XLEN-1:0] fast_res;

  logic [XLEN:0]   mul_sum;
  logic [PW-1:0]   mul_next;
  logic [XLEN:0]   rem_shift, div_diff;
  logic [PW-1:0]   div_next;

  logic [PW-1:0]   fix_in, fix_out;
  logic [XLEN-1:0] fix_sel;

  assign op_in  = mdu_op_t'(funct3);
  assign accept = start && !kill && (state_q == ST_IDLE);

  // ---------------- accept-time operand conditioning ----------------
  always_comb begin
    a_signed = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
               (op_in == OP_DIV)  || (op_in == OP_REM);
    b_signed = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
    neg_a    = a_signed && srcA[XLEN-1];
    neg_b    = b_signed && srcB[XLEN-1];
    // Remainder takes the dividend's sign; everything else the product of signs.
    res_neg  = (op_in == OP_REM) ? neg_a : (neg_a ^ neg_b);
  end

  mdu_neg #(.W(XLEN)) u_neg_a (.a(srcA), .neg(neg_a), .y(a_mag));
  mdu_neg #(.W(XLEN)) u_neg_b (.a(srcB), .neg(neg_b), .y(b_mag));

  always_comb begin
    div_zero = op_is_div(op_in) && (srcB == '0);
    div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
               (srcA == {1'b1, {(XLEN-1){1'b0}}}) && (srcB == '1);
    fast     = div_zero || div_ovf;
    if (div_zero) fast_res = op_in[1] ? srcA : '1;
    else          fast_res = op_in[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // ---------------- per-cycle datapath step ----------------
  // Multiply: prod_q = {acc, multiplier}; add multiplicand on LSB, shift right.
  // Divide:   prod_q = {rem, dividend}; shift left, trial-subtract divisor.
  always_comb begin
    mul_sum   = {1'b0, prod_q[PW-1:XLEN]} + {1'b0, (prod_q[0] ? a_q : {XLEN{1'b0}})};
    mul_next  = {mul_sum, prod_q[XLEN-1:1]};
    rem_shift = prod_q[PW-1:XLEN-1];
    div_diff  = rem_shift - {1'b0, b_q};
    if (div_diff[XLEN]) div_next = {rem_shift[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
    else                div_next = {div_diff[XLEN-1:0],  prod_q[XLEN-2:0], 1'b1};
  end

  // ---------------- fix-up ----------------
  always_comb begin
    if (!op_q[2])     fix_in = prod_q;
    else if (op_q[1]) fix_in = {{XLEN{1'b0}}, prod_q[PW-1:XLEN]};
    else              fix_in = {{XLEN{1'b0}}, prod_q[XLEN-1:0]};
  end

  mdu_neg #(.W(PW)) u_neg_fix (.a(fix_in), .neg(res_neg_q), .y(fix_out));

  assign fix_sel = ((op_q == OP_MUL) || op_q[2]) ? fix_out[XLEN-1:0]
                                                 : fix_out[PW-1:XLEN];

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = fast ? ST_DONE : ST_CALC;
      ST_CALC: begin
        if (kill)                        state_d = ST_IDLE;
        else if (cnt_q == CNT_W'(1))     state_d = ST_FIXUP;
      end
      ST_FIXUP: state_d = kill ? ST_IDLE : ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q      <= OP_MUL;
      a_q       <= '0;
      b_q       <= '0;
      prod_q    <= '0;
      cnt_q     <= '0;
      res_neg_q <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= (state_q == ST_DONE) && !kill;
      if (accept) begin
        op_q      <= op_in;
        a_q       <= a_mag;
        b_q       <= b_mag;
        cnt_q     <= CNT_W'(XLEN);
        res_neg_q <= res_neg;
        prod_q    <= op_in[2] ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
        if (fast) result_q <= fast_res;
      end else if (state_q == ST_CALC && !kill) begin
        cnt_q  <= cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        prod_q <= op_q[2] ? div_next : mul_next;
      end else if (state_q == ST_FIXUP && !kill) begin
        result_q <= fix_sel;
      end
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_mdu_seq.sv
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] srcA = '0;
  logic [31:0] srcB = '0;
  logic        kill = 1'b0;
  logic        busy, done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_exp = '0;

  mdu_seq #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .srcA(srcA), .srcB(srcB), .kill(kill),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_fast(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    if (!f[2]) return 1'b0;
    if (b == 32'h0) return 1'b1;
    return ((f == 3'b100) || (f == 3'b110)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_mdu(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    logic [31:0] r;
    bit ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = '0;
    case (f)
      3'd0: begin p = ua * ub;             r = p[31:0];  end
      3'd1: begin p = sa * sb;             r = p[63:32]; end
      3'd2: begin p = sa * longint'(ub);   r = p[63:32]; end
      3'd3: begin p = ua * ub;             r = p[63:32]; end
      3'd4: begin
        if (b == 0)   r = 32'hFFFF_FFFF;
        else if (ovf) r = 32'h8000_0000;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0)   r = a;
        else if (ovf) r = 32'h0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Issue one request right now (called shortly after a rising edge, unit idle),
  // follow it to done and check latency, busy and result. If inj_at >= 0, a
  // conflicting start is pulsed that many edges after the accept.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input int inj_at);
    logic [31:0] exp;
    int lat, edges;
    bit seen, busy_drop;
    exp = ref_mdu(f, a, b);
    lat = is_fast(f, a, b) ? 1 : 34;
    funct3 = f; srcA = a; srcB = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy_acc"}, 64'(busy), 64'd1);
    edges = 0; seen = 0; busy_drop = 0;
    while (!seen && edges < 100) begin
      if (edges == inj_at) begin
        start = 1'b1; funct3 = 3'b101; srcA = 32'd100; srcB = 32'd0;
      end
      @(posedge clk); #1;
      start = 1'b0;
      edges++;
      if (done) seen = 1;
      else if (busy !== 1'b1) busy_drop = 1;
    end
    chk({tag, "_done"}, 64'(seen), 64'd1);
    chk({tag, "_lat"}, 64'(edges), 64'(lat));
    chk({tag, "_busy"}, 64'(busy_drop), 64'd0);
    chk({tag, "_res"}, 64'(result), 64'(exp));
    last_exp = exp;
  endtask

  task automatic watch_no_done(input string tag, input int n);
    int hits;
    hits = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (done) hits++;
    end
    chk(tag, 64'(hits), 64'd0);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    // reset state
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // directed vectors
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, "mul", -1);
    @(posedge clk); #1;
    chk("mul_done_pulse", 64'(done), 64'd0);
    chk("mul_res_hold", 64'(result), 64'h0000_0000_FFFF_FFEB);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu", -1);
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh", -1);
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu", -1);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, "div", -1);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, "rem", -1);
    run_op(3'b101, 32'd100, 32'd0, "divu_z", -1);
    run_op(3'b111, 32'd100, 32'd0, "remu_z", -1);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", -1);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf", -1);

    // start re-issued during CALC is ignored
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, "mul_reissue", 3);
    watch_no_done("reissue_no_extra_done", 40);

    // kill 5 cycles after accept
    funct3 = 3'b000; srcA = 32'd12345; srcB = 32'd678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill_busy", 64'(busy), 64'd0);
    chk("kill_done", 64'(done), 64'd0);
    watch_no_done("kill_no_done", 40);
    chk("kill_res_hold", 64'(result), 64'(last_exp));

    // start+kill together in IDLE
    funct3 = 3'b011; srcA = 32'd5; srcB = 32'd5; start = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    chk("startkill_busy", 64'(busy), 64'd0);
    watch_no_done("startkill_no_done", 40);

    // randomized against the reference model (back-to-back issue)
    for (int i = 0; i < 60; i++) begin
      run_op(3'($urandom_range(0, 7)), rnd_operand(), rnd_operand(), "rnd", -1);
    end

    // reset mid-CALC
    funct3 = 3'b100; srcA = 32'd1000; srcB = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    reset = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_result", 64'(result), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    watch_no_done("midrst_no_done", 40);
    run_op(3'b101, 32'd1000, 32'd7, "post_rst", -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving operand/result width in bits (legal values: 8, 16, 32, 64).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port funct3  input  3  RV M-extension op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port srcA  input  XLEN  dividend or multiplicand (rs1).
REQ-007 SHALL have port srcB  input  XLEN  divisor or multiplier (rs2).
REQ-008 SHALL have port kill  input  1  pipeline flush; aborts any operation in flight.
REQ-009 SHALL have port busy  output  1  high in CALC, FIXUP and DONE.
REQ-010 SHALL have port done  output  1  one-cycle pulse; result is valid.
REQ-011 SHALL have port result  output  XLEN  operation result.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, FIXUP, DONE.
REQ-013 SHALL accept a request when start=1, kill=0 and state=IDLE, latching funct3, srcA and srcB.
REQ-014 SHALL ignore start in every state other than IDLE; no queueing.
REQ-015 SHALL convert signed operands to magnitudes on accept and record the result sign.
- MULH: both operands signed.
- MULHSU: srcA signed, srcB unsigned.
- DIV/REM: both operands signed.
REQ-016 SHALL multiply by radix-2 shift-add over a 2*XLEN product, one bit per CALC cycle.
REQ-017 SHALL divide by radix-2 restoring division, one quotient bit per CALC cycle.
REQ-018 SHALL remain in CALC for exactly XLEN cycles, counted by a $clog2(XLEN)+1-bit counter, then enter FIXUP.
REQ-019 SHALL in FIXUP conditionally two's-complement negate the product, quotient or remainder, and select the result.
- MUL: low half of the product.
- MULH/MULHSU/MULHU: high half of the product.
- Remainder sign follows the dividend.
REQ-020 SHALL enter DONE after FIXUP and assert done for exactly one cycle, XLEN+2 edges after the accept edge, then return to IDLE.
REQ-021 SHALL take a fast path for divide by zero: accept edge -> DONE, done one edge later.
- DIV/DIVU result = all ones.
- REM/REMU result = srcA.
REQ-022 SHALL take a fast path for signed overflow (DIV/REM, srcA = most-negative, srcB = all ones): accept edge -> DONE.
- DIV result = most-negative value.
- REM result = 0.
REQ-023 SHALL hold result stable from done until the next accepted request.
REQ-024 SHALL on kill in CALC, FIXUP or DONE return to IDLE at the next edge with done=0 that cycle and no later done for the aborted operation.
REQ-025 SHALL give kill priority over start when both are high in IDLE; no request is accepted.
REQ-026 SHALL accept a new request the cycle after DONE.

Reset
REQ-027 SHALL on reset low immediately force state=IDLE, busy=0, done=0, result=0, and clear counter and operand registers.
REQ-028 SHALL on reset mid-operation discard the operation; after reset release no done appears until a new accept.

Structure
REQ-029 SHALL define in shared package mdu_pkg: enum mdu_op_t (the eight funct3 codes), enum mdu_state_t, and the M-extension funct7 constant 7'b0000001.
REQ-030 SHALL instantiate exactly one sub-module, mdu_neg, a parametrised conditional two's-complement negator, used for both operand magnitudes and FIXUP.
REQ-031 SHALL keep the datapath in mdu_seq; no multiplier primitives are inferred.

Verification (XLEN=32)
REQ-032 SHALL cover MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB, done exactly 34 edges after accept, busy high throughout.
REQ-033 SHALL cover MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE, and MULH with the same operands -> 0x00000000.
REQ-034 SHALL cover DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD, and REM with the same operands -> 0xFFFFFFFF.
REQ-035 SHALL cover the fast paths, each with done one edge after accept:
- DIVU 100/0 -> 0xFFFFFFFF; REMU 100/0 -> 100.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
REQ-036 SHALL cover kill 5 cycles after accept -> busy low next edge and no done; start re-issued during CALC -> ignored, and the original result is unchanged.
REQ-037 SHALL cover reset asserted mid-CALC -> outputs zero immediately; start+kill together in IDLE -> no accept.
